// File: rtl/uart_tx_stream.sv
// UART transmitter fed by a valid/ready stream; frames are sent back-to-back
// with no idle gap when the next word is offered in the final stop cycle.
module uart_tx_stream #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              txd,
    output logic              busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_W + 1);

    if (DATA_W < 1 || DATA_W > 16 || CLKS_PER_BIT < 2 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_check
        $error("uart_tx_stream: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [IW-1:0]     idx, idx_n;
    logic [DATA_W-1:0] shift, shift_n;
    logic              par, par_n;
    logic              txd_n;
    logic              bit_end;
    logic              last_stop;
    logic              accept;

    assign bit_end   = (cnt == CW'(CLKS_PER_BIT - 1));
    assign last_stop = (state == S_STOP) && bit_end && (idx == IW'(STOP_BITS - 1));
    // Ready is forced low while reset is held, since the state already reads IDLE then.
    assign s_ready   = !rst && ((state == S_IDLE) || last_stop);
    assign accept    = s_valid && s_ready;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            par   <= 1'b0;
            txd   <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shift <= shift_n;
            par   <= par_n;
            txd   <= txd_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        par_n   = par;
        txd_n   = txd;
        case (state)
            S_IDLE: begin
                txd_n = 1'b1;
                if (accept) begin
                    state_n = S_START;
                    cnt_n   = '0;
                    idx_n   = '0;
                    shift_n = s_data;
                    par_n   = (^s_data) ^ (PARITY == 1);
                    txd_n   = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = S_DATA;
                    txd_n   = shift[0];
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (idx == IW'(DATA_W - 1)) begin
                        idx_n = '0;
                        if (PARITY != 0) begin
                            state_n = S_PARITY;
                            txd_n   = par;
                        end else begin
                            state_n = S_STOP;
                            txd_n   = 1'b1;
                        end
                    end else begin
                        idx_n   = idx + 1'b1;
                        shift_n = shift >> 1;
                        txd_n   = shift_n[0];
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = S_STOP;
                    txd_n   = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_STOP: begin
                txd_n = 1'b1;
                if (bit_end) begin
                    cnt_n = '0;
                    if (idx == IW'(STOP_BITS - 1)) begin
                        // Accepting here chains straight into the next start bit.
                        idx_n = '0;
                        if (accept) begin
                            state_n = S_START;
                            shift_n = s_data;
                            par_n   = (^s_data) ^ (PARITY == 1);
                            txd_n   = 1'b0;
                        end else begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                txd_n   = 1'b1;
            end
        endcase
    end

endmodule

// File: doc/uart_tx_stream.md
Name: uart_tx_stream

Overview:
Serialises words from a valid/ready stream into an asynchronous UART frame on a single txd line. It sits directly downstream of the stream FIFO and consumes its read port (data/valid/ready) with the same handshake semantics. It supports back-to-back frames with no idle gap, so a FIFO full of data drains at exactly line rate.

Parameters:
DATA_W, 8, payload bits per frame (1..16), sent LSB first
CLKS_PER_BIT, 868, clock cycles per bit period (>=2); 868 = 115200 baud at 100 MHz
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
s_data  input  DATA_W  word to transmit; sampled on accept
s_valid  input  1  upstream has a word
s_ready  output  1  block can accept a word this cycle
txd  output  1  serial line, idle high
busy  output  1  frame in progress (any state other than IDLE)

Behaviour:
- Transfer occurs on a rising edge where s_valid && s_ready. s_data is captured into a shift register. s_ready never depends combinationally on s_valid.
- Reset (async assert, sync-safe deassert): state IDLE, txd=1, busy=0, counters=0. s_ready=0 while rst high, 1 in the first cycle after release. Reset mid-frame aborts the frame immediately: txd returns high with no glitch low, and the partial word is discarded.
- States:
  - IDLE: txd=1. On accept, go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: bit i = word[i], i = 0..DATA_W-1, each held CLKS_PER_BIT cycles. Go to PARITY if PARITY != 0, else STOP.
  - PARITY: txd = XOR of word (even) or its complement (odd), held CLKS_PER_BIT cycles. Go to STOP.
  - STOP: txd=1 for STOP_BITS*CLKS_PER_BIT cycles. Go to IDLE, or to START if a word is accepted in the last STOP cycle.
- txd is driven from a register. txd falls to 0 in the cycle immediately after the accepting edge (latency 1).
- s_ready=1 in IDLE and in the final cycle of the final stop bit, else 0.
- Back-to-back: an accept in the last STOP cycle starts the next start bit on the following cycle, giving zero idle gap.
- Frame length: (1 + DATA_W + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles, exact.
- Baud counter: width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. Bit index counter is $clog2(DATA_W+1) bits wide.
- busy = (state != IDLE). busy stays 1 continuously across back-to-back frames.
- s_valid low in IDLE: remain in IDLE indefinitely, txd=1.
- s_data changes while not ready: ignored. Only the value at the accept edge is transmitted.
- Parameter checks: elaboration-time assertion on illegal values (CLKS_PER_BIT<2, PARITY>2, STOP_BITS not 1/2).

Test Plan:
1. Reset hold. rst=1 for 5 cycles with s_valid=1 -> txd=1, s_ready=0, busy=0, no transfer; s_ready=1 in the first cycle after release.
2. Single frame. CLKS_PER_BIT=4, PARITY=0, s_data=8'hA5 -> txd = 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop), each bit 4 cycles, 40 cycles total. s_ready=0 throughout except the last stop cycle. busy falls after cycle 40.
3. Parity. CLKS_PER_BIT=4, s_data=8'hA5 (four ones) -> parity bit 0 for PARITY=2, 1 for PARITY=1; 44-cycle frame.
4. Back-to-back. Preload 3 words 8'h01, 8'h80, 8'hFF with s_valid held high -> 120 contiguous cycles, no idle-high gap between frames, busy held 1, exactly 3 accepts.
5. Reset mid-frame. Assert rst during DATA bit 3 of 8'h00 -> txd=1 asynchronously within the same cycle. After release, a fresh 8'h3C transmits correctly with no residue from the aborted word.
6. Two stop bits and idle. STOP_BITS=2, CLKS_PER_BIT=4, s_data=8'h5A -> stop high for 8 cycles, 44-cycle frame. With s_valid then low for 20 cycles -> txd=1, s_ready=1, busy=0 throughout.
